// File: rtl/avg_pkg.sv
// Shared constants and types for the 3x3 window-averager sequencer.
package avg_pkg;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_WIDTH      = 24;
    localparam int DEF_PIC_WIDTH  = 250;
    localparam int DEF_PIC_HEIGHT = 250;
    localparam int DEF_FLUSH_LEN  = 3;

    localparam int WIN_LAT = 1;  // accept -> averager strobe
    localparam int AVG_LAT = 1;  // strobe -> averager dout

    localparam int DEF_COL_W = cnt_w(DEF_PIC_WIDTH + DEF_FLUSH_LEN);
    localparam int DEF_ROW_W = cnt_w(DEF_PIC_HEIGHT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROW   = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/avg_line_buffer.sv
// Two read-first line RAMs; sel picks which one holds row y-2 (and is rewritten).
module avg_line_buffer
    import avg_pkg::*;
#(
    parameter  int DEPTH = DEF_PIC_WIDTH,
    parameter  int WIDTH = DEF_WIDTH,
    localparam int AW    = cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             sel,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rd_top,
    output logic [WIDTH-1:0] rd_mid
);

    logic [WIDTH-1:0] mem0 [DEPTH];
    logic [WIDTH-1:0] mem1 [DEPTH];

    always_ff @(posedge clk) begin
        if (en && !sel) mem0[addr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (en && sel) mem1[addr] <= wdata;
    end

    // Read data registers double as the window's top/mid outputs, so they
    // reset to zero and are zeroed on flush strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_top <= '0;
            rd_mid <= '0;
        end else if (en) begin
            rd_top <= sel ? mem1[addr] : mem0[addr];
            rd_mid <= sel ? mem0[addr] : mem1[addr];
        end else if (clr) begin
            rd_top <= '0;
            rd_mid <= '0;
        end
    end

endmodule

// File: rtl/avg_window_ctrl.sv
// Raster-to-window sequencer for the 3x3 averager: line buffers, row/col
// counters, per-row flush strobes and (x, y) tagging of interior results.
module avg_window_ctrl
    import avg_pkg::*;
#(
    parameter  int PIC_WIDTH  = DEF_PIC_WIDTH,
    parameter  int PIC_HEIGHT = DEF_PIC_HEIGHT,
    parameter  int WIDTH      = DEF_WIDTH,
    parameter  int FLUSH_LEN  = DEF_FLUSH_LEN,
    localparam int CW         = cnt_w(PIC_WIDTH + FLUSH_LEN),
    localparam int YW         = cnt_w(PIC_HEIGHT),
    localparam int XW         = cnt_w(PIC_WIDTH),
    localparam int AW         = cnt_w(PIC_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sof,
    input  logic [WIDTH-1:0] in_data,
    output logic             win_valid,
    output logic [WIDTH-1:0] row_top,
    output logic [WIDTH-1:0] row_mid,
    output logic [WIDTH-1:0] row_bot,
    output logic             out_valid,
    output logic [XW-1:0]    out_x,
    output logic [YW-1:0]    out_y,
    output logic             frame_done,
    output logic             sof_err,
    output logic             busy
);

    localparam int STAGES = WIN_LAT + AVG_LAT - 1;

    localparam logic [CW-1:0] COL_LAST_PIX = CW'(PIC_WIDTH - 1);
    localparam logic [CW-1:0] COL_LAST     = CW'(PIC_WIDTH + FLUSH_LEN - 1);
    localparam logic [CW-1:0] TAG_LO       = CW'(4);
    // Last interior centre (PIC_WIDTH-2) leaves the averager at strobe PIC_WIDTH+1.
    localparam logic [CW-1:0] TAG_HI       = CW'(PIC_WIDTH + 1);
    localparam logic [YW-1:0] Y_LAST       = YW'(PIC_HEIGHT - 1);
    localparam logic [YW-1:0] Y_TAG_LO     = YW'(2);

    state_t        state, state_n;
    logic [CW-1:0] col, col_n;
    logic [YW-1:0] y, y_n;
    logic          accept, proc, flush_cyc, strobe;

    assign in_ready  = !rst && (state != FLUSH);
    assign accept    = in_valid && in_ready;
    assign proc      = accept && ((state != IDLE) || in_sof);
    assign flush_cyc = (state == FLUSH);
    assign strobe    = proc || flush_cyc;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col   <= '0;
            y     <= '0;
        end else begin
            state <= state_n;
            col   <= col_n;
            y     <= y_n;
        end
    end

    always_comb begin
        state_n = state;
        col_n   = col;
        y_n     = y;
        case (state)
            IDLE: begin
                if (proc) begin
                    state_n = ROW;
                    col_n   = CW'(1);
                end
            end
            ROW: begin
                if (accept) begin
                    col_n = col + 1'b1;
                    if (col == COL_LAST_PIX) state_n = FLUSH;
                end
            end
            FLUSH: begin
                col_n = col + 1'b1;
                if (col == COL_LAST) begin
                    col_n = '0;
                    if (y == Y_LAST) begin
                        state_n = IDLE;
                        y_n     = '0;
                    end else begin
                        state_n = ROW;
                        y_n     = y + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    avg_line_buffer #(
        .DEPTH (PIC_WIDTH),
        .WIDTH (WIDTH)
    ) u_lbuf (
        .clk    (clk),
        .rst    (rst),
        .en     (proc),
        .clr    (flush_cyc),
        .sel    (y[0]),
        .addr   (col[AW-1:0]),
        .wdata  (in_data),
        .rd_top (row_top),
        .rd_mid (row_mid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_valid <= 1'b0;
            row_bot   <= '0;
            sof_err   <= 1'b0;
        end else begin
            win_valid <= strobe;
            sof_err   <= accept && in_sof && (state != IDLE);
            if (proc)           row_bot <= in_data;
            else if (flush_cyc) row_bot <= '0;
        end
    end

    // Tagging counts strobes rather than cycles, so input gaps cannot skew it.
    logic          tag_vld, tag_done;
    logic [XW-1:0] tag_x;
    logic [YW-1:0] tag_y;

    assign tag_vld  = strobe && (col >= TAG_LO) && (col <= TAG_HI) && (y >= Y_TAG_LO);
    assign tag_done = tag_vld && (col == TAG_HI) && (y == Y_LAST);
    assign tag_x    = XW'(col - CW'(3));
    assign tag_y    = y - 1'b1;

    logic [STAGES:0] vld_pipe, done_pipe;
    logic [XW-1:0]   x_pipe [STAGES+1];
    logic [YW-1:0]   y_pipe [STAGES+1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe  <= '0;
            done_pipe <= '0;
            for (int i = 0; i <= STAGES; i++) begin
                x_pipe[i] <= '0;
                y_pipe[i] <= '0;
            end
        end else begin
            vld_pipe  <= {vld_pipe[STAGES-1:0], tag_vld};
            done_pipe <= {done_pipe[STAGES-1:0], tag_done};
            if (tag_vld) begin
                x_pipe[0] <= tag_x;
                y_pipe[0] <= tag_y;
            end
            for (int i = 1; i <= STAGES; i++) begin
                if (vld_pipe[i-1]) begin
                    x_pipe[i] <= x_pipe[i-1];
                    y_pipe[i] <= y_pipe[i-1];
                end
            end
        end
    end

    assign out_valid  = vld_pipe[STAGES];
    assign frame_done = done_pipe[STAGES];
    assign out_x      = x_pipe[STAGES];
    assign out_y      = y_pipe[STAGES];

endmodule

// File: tb/tb_avg_window_ctrl.sv
// Directed bench for avg_window_ctrl on an 8x4 frame with a behavioural 3x3 averager.
module tb_avg_window_ctrl;

    localparam int PW     = 8;
    localparam int PH     = 4;
    localparam int FL     = 3;
    localparam int ROWLEN = PW + FL;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_sof = 1'b0;
    logic [23:0] in_data = '0;
    logic        in_ready, win_valid, out_valid, frame_done, sof_err, busy;
    logic [23:0] row_top, row_mid, row_bot;
    logic [2:0]  out_x;
    logic [1:0]  out_y;

    always #5 clk = ~clk;

    avg_window_ctrl #(
        .PIC_WIDTH  (PW),
        .PIC_HEIGHT (PH),
        .WIDTH      (24),
        .FLUSH_LEN  (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sof     (in_sof),
        .in_data    (in_data),
        .win_valid  (win_valid),
        .row_top    (row_top),
        .row_mid    (row_mid),
        .row_bot    (row_bot),
        .out_valid  (out_valid),
        .out_x      (out_x),
        .out_y      (out_y),
        .frame_done (frame_done),
        .sof_err    (sof_err),
        .busy       (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [23:0] pix(input int pat, input int x, input int y);
        case (pat)
            0:       return 24'h102030;
            1:       return {8'(x), 8'(y), 8'h00};
            default: return {8'(x * 30 + y), 8'(y * 50 + 7), 8'(x * x + 3)};
        endcase
    endfunction

    function automatic logic [23:0] avg_px(input logic [8:0][23:0] p);
        logic [23:0] r;
        int sum;
        for (int ch = 0; ch < 3; ch++) begin
            sum = 0;
            for (int i = 0; i < 9; i++) sum += int'(p[i][ch*8 +: 8]);
            r[ch*8 +: 8] = 8'(sum / 9);
        end
        return r;
    endfunction

    function automatic logic [23:0] exp_avg(input int pat, input int x, input int y);
        logic [8:0][23:0] p;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++)
                p[dy*3 + dx] = pix(pat, x + dx - 1, y + dy - 1);
        return avg_px(p);
    endfunction

    // Stand-in for the averager: dout after strobe s = mean of strobes s-2..s-4.
    logic [2:0][23:0] hist [4];
    logic [23:0]      dout = '0;

    always @(posedge clk) begin
        if (win_valid) begin
            hist[0] <= {row_top, row_mid, row_bot};
            hist[1] <= hist[0];
            hist[2] <= hist[1];
            hist[3] <= hist[2];
            dout    <= avg_px({hist[1], hist[2], hist[3]});
        end
    end

    typedef struct { int x; int y; logic [23:0] d; logic done; } res_t;
    res_t results[$];
    int   strobe_k = 0;
    int   fd_cnt   = 0;
    int   sof_cnt  = 0;
    int   cur_pat  = 0;

    always @(negedge clk) begin
        int s, r;
        if (rst) begin
            strobe_k = 0;
        end else begin
            if (win_valid) begin
                s = strobe_k % ROWLEN;
                r = strobe_k / ROWLEN;
                if (s < PW) begin
                    chk("row_bot", int'(row_bot), int'(pix(cur_pat, s, r)));
                    if (r >= 1) chk("row_mid", int'(row_mid), int'(pix(cur_pat, s, r - 1)));
                    if (r >= 2) chk("row_top", int'(row_top), int'(pix(cur_pat, s, r - 2)));
                end else begin
                    chk("flush_rows_zero", int'(row_top | row_mid | row_bot), 0);
                end
                strobe_k++;
            end
            if (out_valid) results.push_back('{int'(out_x), int'(out_y), dout, frame_done});
            if (frame_done) fd_cnt++;
            if (sof_err) sof_cnt++;
        end
    end

    task automatic clear_mon();
        results.delete();
        strobe_k = 0;
        fd_cnt   = 0;
        sof_cnt  = 0;
    endtask

    task automatic push(input logic [23:0] d, input logic sof, input int gap);
        int  g = 0;
        int  n = 0;
        logic acc = 1'b0;
        while (gap > 0 && $urandom_range(0, 99) < gap && g < 20) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
            g++;
        end
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        while (!acc && n < 50) begin
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        in_sof   = 1'b0;
        if (!acc) chk("accept_timeout", 0, 1);
    endtask

    task automatic finish_frame(input int exp_res, input int exp_stb, input int exp_sof);
        int n = 0;
        while (fd_cnt == 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        repeat (6) begin @(posedge clk); #1; end
        chk("result_count", results.size(), exp_res);
        for (int i = 0; i < results.size() && i < exp_res; i++) begin
            chk($sformatf("res%0d_x", i), results[i].x, 1 + i % (PW - 2));
            chk($sformatf("res%0d_y", i), results[i].y, 1 + i / (PW - 2));
            chk($sformatf("res%0d_dout", i), int'(results[i].d),
                int'(exp_avg(cur_pat, 1 + i % (PW - 2), 1 + i / (PW - 2))));
            chk($sformatf("res%0d_done", i), int'(results[i].done), int'(i == exp_res - 1));
        end
        chk("frame_done_count", fd_cnt, 1);
        chk("strobe_count", strobe_k, exp_stb);
        chk("sof_err_count", sof_cnt, exp_sof);
        chk("busy_after_frame", int'(busy), 0);
    endtask

    task automatic run_frame(input int pat, input int gap, input int junk, input int sof_at);
        clear_mon();
        cur_pat = pat;
        for (int j = 0; j < junk; j++) push(24'hABCDEF, 1'b0, 0);
        for (int i = 0; i < PW * PH; i++)
            push(pix(pat, i % PW, i / PW), (i == 0) || (i == sof_at), gap);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},   int'(in_ready),   0);
        chk({tag, "_win_valid"},  int'(win_valid),  0);
        chk({tag, "_rows"},       int'(row_top | row_mid | row_bot), 0);
        chk({tag, "_out_valid"},  int'(out_valid),  0);
        chk({tag, "_out_xy"},     int'({out_x, out_y}), 0);
        chk({tag, "_frame_done"}, int'(frame_done), 0);
        chk({tag, "_sof_err"},    int'(sof_err),    0);
        chk({tag, "_busy"},       int'(busy),       0);
    endtask

    typedef struct {
        int pat; int gap; int junk; int sof_at;
        int exp_res; int exp_stb; int exp_sof;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int acc_n, guard, zc;
        logic acc;

        vecs[0] = '{0,  0, 0, -1, 12, 44, 0};  // constant frame
        vecs[1] = '{1,  0, 0, -1, 12, 44, 0};  // {x, y, 0} ramp
        vecs[2] = '{2,  0, 0, -1, 12, 44, 0};  // asymmetric pattern
        vecs[3] = '{2, 50, 0, -1, 12, 44, 0};  // random input gaps
        vecs[4] = '{1,  0, 3, -1, 12, 44, 0};  // junk pixels dropped in IDLE
        vecs[5] = '{0,  0, 0, 11, 12, 44, 1};  // in_sof at (3,1)
        vecs[6] = '{1, 50, 0, 11, 12, 44, 1};  // gaps plus stray sof

        #1;
        chk_reset_outputs("por");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_in_ready", int'(in_ready), 1);

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].pat, vecs[v].gap, vecs[v].junk, vecs[v].sof_at);
            finish_frame(vecs[v].exp_res, vecs[v].exp_stb, vecs[v].exp_sof);
        end

        // Back-pressure: in_valid held high for a whole frame.
        clear_mon();
        cur_pat  = 0;
        acc_n    = 0;
        guard    = 0;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        in_data  = pix(0, 0, 0);
        while (acc_n < PW * PH && guard < 400) begin
            acc = in_ready;
            @(posedge clk); #1;
            guard++;
            if (acc) begin
                acc_n++;
                in_sof  = 1'b0;
                in_data = pix(0, acc_n % PW, acc_n / PW);
                if (acc_n == PW * PH) in_valid = 1'b0;
                if (acc_n % PW == 0) begin
                    zc = 0;
                    while (!in_ready && zc < 10) begin
                        zc++;
                        @(posedge clk); #1;
                    end
                    chk($sformatf("ready_low_row%0d", acc_n / PW - 1), zc, FL);
                end
            end
        end
        in_valid = 1'b0;
        chk("bp_accepts", acc_n, PW * PH);
        finish_frame(12, 44, 0);

        // Reset in the middle of row 2, then a fresh frame.
        clear_mon();
        cur_pat = 1;
        for (int i = 0; i < 2 * PW + 5; i++) push(pix(1, i % PW, i / PW), i == 0, 0);
        rst = 1'b1;
        #1;
        chk_reset_outputs("mid_rst");
        @(posedge clk); #1;
        chk_reset_outputs("mid_rst_hold");
        rst = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("post_rst_no_results", results.size(), 0);
        run_frame(1, 0, 0, -1);
        finish_frame(12, 44, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish, expected finish");
        $fatal(1);
    end

endmodule
